imem_loader: RTL and testbench

Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake, decodes a length header, assembles little-endian 32-bit instruction words and writes them into instruction memory one word per write cycle. It then checks an XOR checksum and releases the core from reset. It sits between a host byte source (UART receiver or bench) and the write port of `inst_mem`, and drives the reset of `PC`, `ID`, `Registers` and `DataMem`.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader_word_assembler.sv | 42 ++++
 rtl/imem_loader.sv | 104 ++++++++++
 tb/tb_imem_loader.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs payload bytes little-endian into a 32-bit word and keeps the running XOR checksum.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_merged,
  output logic [7:0]  checksum,
  output logic        word_full
);

  logic [31:0] word;
  logic [1:0]  byte_idx;

  // word_merged already contains the byte being accepted, so the write can use it directly
  always_comb begin
    word_merged = word;
    if (en) word_merged[{byte_idx, 3'b000} +: 8] = byte_in;
  end

  assign word_full = en && (byte_idx == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word     <= '0;
      byte_idx <= '0;
      checksum <= '0;
    end else if (clear) begin
      word     <= '0;
      byte_idx <= '0;
      checksum <= '0;
    end else if (en) begin
      word     <= word_merged;
      byte_idx <= byte_idx + 2'd1;
      checksum <= checksum ^ byte_in;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives length header + payload + checksum, writes instruction memory, releases core reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         core_rst,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned CAPACITY = 32'd1 << ADDR_W;

  state_t                 state, next_state;
  logic [HDR_BYTES*8-1:0] len, len_next;
  logic [ADDR_W:0]        addr;
  logic                   accept, asm_clear, asm_en, word_full;
  logic                   last_word, len_too_big;
  logic [31:0]            word_merged;
  logic [7:0]             checksum;

  assign accept      = bus.byte_valid && bus.byte_ready;
  assign len_next    = {bus.byte_data, len[7:0]};
  assign len_too_big = 32'(len_next) > CAPACITY;
  assign last_word   = (32'(addr) + 32'd1) == 32'(len);
  assign asm_clear   = start && (state inside {S_IDLE, S_DONE, S_ERR});
  assign asm_en      = accept && (state == S_DATA);

  word_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear       (asm_clear),
    .en          (asm_en),
    .byte_in     (bus.byte_data),
    .word_merged (word_merged),
    .checksum    (checksum),
    .word_full   (word_full)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (start) next_state = S_LEN_LO;
      S_LEN_LO: if (accept) next_state = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (len_too_big)          next_state = S_ERR;
          else if (len_next == '0)  next_state = S_CHK;
          else                      next_state = S_DATA;
        end
      end
      S_DATA:  if (word_full) next_state = S_WRITE;
      S_WRITE: next_state = last_word ? S_CHK : S_DATA;
      S_CHK:   if (accept) next_state = (bus.byte_data == checksum) ? S_DONE : S_ERR;
      default: next_state = S_IDLE;
    endcase
  end

  // addr is one bit wider than im_addr so a full-capacity load never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      len   <= '0;
      addr  <= '0;
    end else begin
      state <= next_state;
      if (asm_clear)                         addr <= '0;
      else if (state == S_WRITE && !last_word) addr <= addr + (ADDR_W+1)'(1);
      if (state == S_LEN_LO && accept)       len[7:0] <= bus.byte_data;
      if (state == S_LEN_HI && accept)       len <= len_next;
    end
  end

  // Outputs are decoded from next_state so they are registered yet valid throughout each state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.byte_ready <= 1'b0;
      bus.im_we      <= 1'b0;
      bus.im_addr    <= '0;
      bus.im_wdata   <= '0;
      core_rst       <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      bus.byte_ready <= next_state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK};
      bus.im_we      <= next_state == S_WRITE;
      if (next_state == S_WRITE) begin
        bus.im_addr  <= addr[ADDR_W-1:0];
        bus.im_wdata <= word_merged;
      end
      core_rst <= next_state != S_DONE;
      busy     <= next_state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK};
      done     <= next_state == S_DONE;
      err      <= next_state == S_ERR;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with ADDR_W=8.
module tb_imem_loader;

  logic clk, rst, start;
  logic core_rst, busy, done, err;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   double_we = 0;
  logic prev_we = 1'b0;

  logic [7:0]  stream[$];
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor: logs every write and flags consecutive write pulses
  always @(negedge clk) begin
    if (bus.im_we) begin
      wr_addr.push_back(bus.im_addr);
      wr_data.push_back(bus.im_wdata);
    end
    if (bus.im_we && prev_we) double_we++;
    prev_we = bus.im_we;
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL byte_timeout: byte_ready stayed %b for 50 cycles, want 1", bus.byte_ready);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int max_gap);
    for (int i = lo; i < hi; i++)
      send_byte(stream[i], (max_gap == 0) ? 0 : (i * 7) % (max_gap + 1));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.byte_ready, bus.im_we, core_rst, busy, done, err} !== 6'b001000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: ready,we,core_rst,busy,done,err got %b want 001000",
               {bus.byte_ready, bus.im_we, core_rst, busy, done, err});
    end
    tests_run++;
    if (bus.im_addr !== 8'h00 || bus.im_wdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_bus: addr %h data %h want 00 00000000", bus.im_addr, bus.im_wdata);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (core_rst !== 1'b1 || bus.byte_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_flags: core_rst %b ready %b want 1 0", core_rst, bus.byte_ready);
    end
  endtask

  task automatic test_single();
    int c0;
    clear_log();
    stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    c0 = cyc;
    do_start();
    tests_run++;
    if (bus.byte_ready !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL start_len_lo: ready %b busy %b want 1 1", bus.byte_ready, busy);
    end
    send_range(0, stream.size(), 0);
    tests_run++;
    if (cyc - c0 !== 9) begin
      tests_failed++;
      $display("[TB] FAIL single_latency: got %0d cycles want 9", cyc - c0);
    end
    tests_run++;
    if ({done, err, core_rst, busy} !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL single_status: done,err,core_rst,busy got %b want 1000", {done, err, core_rst, busy});
    end
    tests_run++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h00000013) begin
      tests_failed++;
      $display("[TB] FAIL single_write: count %0d first %h/%h want 1 00/00000013",
               wr_addr.size(), wr_addr.size() ? wr_addr[0] : 8'h0, wr_data.size() ? wr_data[0] : 32'h0);
    end
  endtask

  // Checksum of 93 00 50 00 13 01 A0 00 is 0x71
  task automatic test_two_words(input int max_gap, input bit mid_start);
    int c0;
    clear_log();
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    c0 = cyc;
    do_start();
    if (mid_start) begin
      send_range(0, 5, max_gap);
      do_start();
      tests_run++;
      if (busy !== 1'b1 || bus.byte_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL mid_start_ignored: busy %b ready %b want 1 1", busy, bus.byte_ready);
      end
      send_range(5, stream.size(), max_gap);
    end else begin
      send_range(0, stream.size(), max_gap);
      tests_run++;
      if (cyc - c0 !== 14) begin
        tests_failed++;
        $display("[TB] FAIL two_latency: got %0d cycles want 14", cyc - c0);
      end
    end
    tests_run++;
    if (done !== 1'b1 || core_rst !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL two_done: done %b core_rst %b want 1 0", done, core_rst);
    end
    tests_run++;
    if (wr_addr.size() !== 2) begin
      tests_failed++;
      $display("[TB] FAIL two_count: got %0d writes want 2", wr_addr.size());
    end else begin
      tests_run++;
      if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h00500093 || wr_addr[1] !== 8'h01 || wr_data[1] !== 32'h00A00113) begin
        tests_failed++;
        $display("[TB] FAIL two_data: got %h/%h %h/%h want 00/00500093 01/00A00113",
                 wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
    end
  endtask

  task automatic test_zero_len();
    int c0;
    clear_log();
    stream = '{8'h00, 8'h00, 8'h00};
    c0 = cyc;
    do_start();
    send_range(0, stream.size(), 0);
    tests_run++;
    if (cyc - c0 !== 4 || done !== 1'b1 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zero_len: cycles %0d done %b err %b want 4 1 0", cyc - c0, done, err);
    end
    tests_run++;
    if (wr_addr.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL zero_writes: got %0d writes want 0", wr_addr.size());
    end
  endtask

  task automatic test_too_long();
    clear_log();
    stream = '{8'h01, 8'h01};
    do_start();
    send_range(0, stream.size(), 0);
    tests_run++;
    if ({err, done, busy, core_rst, bus.byte_ready} !== 5'b10010) begin
      tests_failed++;
      $display("[TB] FAIL too_long: err,done,busy,core_rst,ready got %b want 10010",
               {err, done, busy, core_rst, bus.byte_ready});
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (wr_addr.size() !== 0 || bus.byte_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL too_long_quiet: writes %0d ready %b want 0 0", wr_addr.size(), bus.byte_ready);
    end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    do_start();
    send_range(0, stream.size(), 0);
    tests_run++;
    if ({err, done, core_rst} !== 3'b101) begin
      tests_failed++;
      $display("[TB] FAIL bad_chk: err,done,core_rst got %b want 101", {err, done, core_rst});
    end
    tests_run++;
    if (wr_addr.size() !== 1) begin
      tests_failed++;
      $display("[TB] FAIL bad_chk_writes: got %0d want 1", wr_addr.size());
    end
  endtask

  // 256 words: word i holds i in its low byte, so the XOR of all payload bytes is 0
  task automatic test_full_capacity();
    int c0;
    int bad = 0;
    clear_log();
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h01);
    for (int i = 0; i < 256; i++) begin
      stream.push_back(8'(i));
      repeat (3) stream.push_back(8'h00);
    end
    stream.push_back(8'h00);
    c0 = cyc;
    do_start();
    send_range(0, stream.size(), 0);
    tests_run++;
    if (cyc - c0 !== 1284 || done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL full_done: cycles %0d done %b want 1284 1", cyc - c0, done);
    end
    tests_run++;
    if (wr_addr.size() !== 256) begin
      tests_failed++;
      $display("[TB] FAIL full_count: got %0d writes want 256", wr_addr.size());
    end else begin
      for (int i = 0; i < 256; i++)
        if (wr_addr[i] !== 8'(i) || wr_data[i] !== 32'(i)) bad++;
      tests_run++;
      if (bad !== 0) begin
        tests_failed++;
        $display("[TB] FAIL full_data: %0d bad words, last %h/%h want 0 bad, last ff/000000ff",
                 bad, wr_addr[255], wr_data[255]);
      end
    end
    tests_run++;
    if (double_we !== 0) begin
      tests_failed++;
      $display("[TB] FAIL we_pulse: %0d back-to-back im_we cycles want 0", double_we);
    end
  endtask

  // DE^AD^BE^EF = 0x22
  task automatic test_reset_mid_load();
    clear_log();
    stream = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_start();
    send_range(0, stream.size(), 1);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus.byte_ready, bus.im_we, core_rst, busy, done, err} !== 6'b001000 ||
        bus.im_addr !== 8'h00 || bus.im_wdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_outputs: flags %b addr %h data %h want 001000 00 00000000",
               {bus.byte_ready, bus.im_we, core_rst, busy, done, err}, bus.im_addr, bus.im_wdata);
    end
    tests_run++;
    if (wr_addr.size() !== 1 || wr_data[0] !== 32'h44332211) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_prior: count %0d want 1 with 44332211", wr_addr.size());
    end
    rst = 1'b1;
    @(negedge clk);
    clear_log();
    stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    do_start();
    send_range(0, stream.size(), 0);
    tests_run++;
    if (done !== 1'b1 || wr_addr.size() !== 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL reload: done %b count %0d want 1 1 at 00 deadbeef", done, wr_addr.size());
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    test_reset();
    test_single();
    test_two_words(0, 1'b0);
    test_zero_len();
    test_too_long();
    test_bad_checksum();
    test_two_words(3, 1'b1);
    test_full_capacity();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
